// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the HD44780-style display responder.
package lcd_pkg;

  // Command opcodes; a command is identified by its highest set bit.
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNCSET = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [6:0] ROW0_BASE = 7'h00;
  localparam logic [6:0] ROW1_BASE = 7'h40;
  localparam logic [6:0] ROW0_END  = 7'h27;
  localparam logic [6:0] ROW1_END  = 7'h67;

  // Step the DDRAM address counter, wrapping between rows. Addresses in the gap
  // above a row end behave as if they sat on that row end.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac[5:0] >= 6'h27) nxt = ac[6] ? ROW0_BASE : ROW1_BASE;
      else                  nxt = ac + 7'd1;
    end else begin
      if (ac[5:0] == 6'h00)     nxt = ac[6] ? ROW0_END : ROW1_END;
      else if (ac[5:0] > 6'h27) nxt = {ac[6], 6'h27};
      else                      nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_responder_if.sv
// Driver-to-display strobe bus: enable, register select and DB7..DB4 nibble.
interface lcd_responder_if;
  logic       en;
  logic       rs;
  logic [3:0] data;

  modport master (output en, rs, data);
  modport slave  (input  en, rs, data);
endinterface

// File: rtl/lcd_nibble_rx.sv
// Strobe detect and nibble pairing for the display responder.
// Optional macro LCD_RESPONDER_SYNC_EN adds a 2-flop input synchroniser.
module lcd_nibble_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       rs_i,
  input  logic [3:0] data_i,
  input  logic       busy_i,
  input  logic       mode_set_i,
  input  logic       mode_4bit_set_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_rs_o,
  output logic       mode_4bit_o,
  output logic       overrun_o
);

  logic       en_s, rs_s;
  logic [3:0] data_s;

`ifdef LCD_RESPONDER_SYNC_EN
  logic [1:0] en_sync_q, rs_sync_q;
  logic [3:0] data_sync0_q, data_sync1_q;

  // Two-stage synchroniser for an asynchronous driver.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_sync_q    <= '0;
      rs_sync_q    <= '0;
      data_sync0_q <= '0;
      data_sync1_q <= '0;
    end else begin
      en_sync_q    <= {en_sync_q[0], en_i};
      rs_sync_q    <= {rs_sync_q[0], rs_i};
      data_sync0_q <= data_i;
      data_sync1_q <= data_sync0_q;
    end
  end

  assign en_s   = en_sync_q[1];
  assign rs_s   = rs_sync_q[1];
  assign data_s = data_sync1_q;
`else
  assign en_s   = en_i;
  assign rs_s   = rs_i;
  assign data_s = data_i;
`endif

  logic       en_q, rs_q, phase_hi_q, mode_4bit_q;
  logic [3:0] data_q, hi_q;
  logic       strobe;

  assign strobe = en_q & ~en_s;

  // Byte assembly: complete on every strobe in 8-bit mode, every second in 4-bit.
  always_comb begin
    byte_valid_o = strobe & ~busy_i & (~mode_4bit_q | ~phase_hi_q);
    byte_o       = mode_4bit_q ? {hi_q, data_q} : {data_q, 4'h0};
    byte_rs_o    = rs_q;
    overrun_o    = strobe & busy_i;
  end

  assign mode_4bit_o = mode_4bit_q;

  // Strobe-detect registers, nibble phase and interface width.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      hi_q        <= '0;
      phase_hi_q  <= 1'b1;
      mode_4bit_q <= 1'b0;
    end else begin
      en_q   <= en_s;
      rs_q   <= rs_s;
      data_q <= data_s;
      if (mode_set_i) begin
        mode_4bit_q <= mode_4bit_set_i;
        phase_hi_q  <= 1'b1;
      end else if (strobe && !busy_i && mode_4bit_q) begin
        if (phase_hi_q) hi_q <= data_q;
        phase_hi_q <= ~phase_hi_q;
      end
    end
  end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-compatible display-side model: command execution, two-row DDRAM,
// clear sweep and registered readback.
// Optional macro LCD_RESPONDER_SYNC_EN (see lcd_nibble_rx).
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned DDRAM_COLS = 16,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic                clk,
  input  logic                reset,
  lcd_responder_if.slave      bus,
  input  logic [6:0]          rd_addr_i,
  output logic [7:0]          rd_data_o,
  output logic                cmd_stb_o,
  output logic                dat_stb_o,
  output logic [7:0]          byte_out_o,
  output logic [6:0]          ac_o,
  output logic                mode_4bit_o,
  output logic [2:0]          disp_ctl_o,
  output logic                entry_id_o,
  output logic                busy_o,
  output logic                err_overrun_o
);

  localparam int unsigned Cells = 2 * DDRAM_COLS;
  localparam int unsigned AW    = $clog2(Cells);

  logic          rx_valid, rx_rs, rx_overrun, mode_set, mode_val;
  logic [7:0]    rx_byte;

  lcd_nibble_rx u_rx (
    .clk             (clk),
    .reset           (reset),
    .en_i            (bus.en),
    .rs_i            (bus.rs),
    .data_i          (bus.data),
    .busy_i          (busy_o),
    .mode_set_i      (mode_set),
    .mode_4bit_set_i (mode_val),
    .byte_valid_o    (rx_valid),
    .byte_o          (rx_byte),
    .byte_rs_o       (rx_rs),
    .mode_4bit_o     (mode_4bit_o),
    .overrun_o       (rx_overrun)
  );

  logic [6:0]    ac_q, ac_d;
  logic [2:0]    disp_ctl_q, disp_ctl_d;
  logic          entry_id_q, entry_id_d, busy_q, busy_d;
  logic [AW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic          err_overrun_q, cmd_stb_q, dat_stb_q;
  logic [7:0]    byte_out_q, rd_data_q;
  logic [7:0]    ram [Cells];

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          ac_mapped, rd_mapped;
  logic [AW-1:0] ac_idx, rd_idx;

  // Row/column to flat cell index; columns beyond DDRAM_COLS are not stored.
  assign ac_mapped = 32'(ac_q[5:0]) < DDRAM_COLS;
  assign ac_idx    = AW'(32'(ac_q[6]) * DDRAM_COLS + 32'(ac_q[5:0]));
  assign rd_mapped = 32'(rd_addr_i[5:0]) < DDRAM_COLS;
  assign rd_idx    = AW'(32'(rd_addr_i[6]) * DDRAM_COLS + 32'(rd_addr_i[5:0]));

  // Command/data execution and sweep sequencing.
  always_comb begin
    ac_d        = ac_q;
    disp_ctl_d  = disp_ctl_q;
    entry_id_d  = entry_id_q;
    busy_d      = busy_q;
    sweep_cnt_d = sweep_cnt_q;
    mode_set    = 1'b0;
    mode_val    = 1'b0;
    we          = 1'b0;
    waddr       = sweep_cnt_q;
    wdata       = CLEAR_CHAR;
    if (busy_q) begin
      we          = 1'b1;
      sweep_cnt_d = sweep_cnt_q + AW'(1);
      if (sweep_cnt_q == AW'(Cells - 1)) busy_d = 1'b0;
    end
    // rx never yields a byte while busy, so the RAM port is never contended.
    if (rx_valid) begin
      if (rx_rs) begin
        if (ac_mapped) begin
          we    = 1'b1;
          waddr = ac_idx;
          wdata = rx_byte;
        end
        ac_d = ac_step(ac_q, entry_id_q);
      end else if (|(rx_byte & CMD_DDRAM)) begin
        ac_d = rx_byte[6:0];
      end else if (|(rx_byte & CMD_CGRAM)) begin
        // No CGRAM modelled; only the strobe is reported.
      end else if (|(rx_byte & CMD_FUNCSET)) begin
        mode_set = 1'b1;
        mode_val = ~rx_byte[4];
      end else if (|(rx_byte & CMD_SHIFT)) begin
        if (!rx_byte[3]) ac_d = ac_step(ac_q, rx_byte[2]);
      end else if (|(rx_byte & CMD_DISPCTL)) begin
        disp_ctl_d = rx_byte[2:0];
      end else if (|(rx_byte & CMD_ENTRY)) begin
        entry_id_d = rx_byte[1];
      end else if (|(rx_byte & CMD_HOME)) begin
        ac_d = '0;
      end else if (|(rx_byte & CMD_CLEAR)) begin
        ac_d        = '0;
        entry_id_d  = 1'b1;
        busy_d      = 1'b1;
        sweep_cnt_d = '0;
      end
    end
  end

  // Control/status state and strobe pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ac_q          <= '0;
      disp_ctl_q    <= '0;
      entry_id_q    <= 1'b1;
      busy_q        <= 1'b0;
      sweep_cnt_q   <= '0;
      err_overrun_q <= 1'b0;
      cmd_stb_q     <= 1'b0;
      dat_stb_q     <= 1'b0;
      byte_out_q    <= '0;
    end else begin
      ac_q          <= ac_d;
      disp_ctl_q    <= disp_ctl_d;
      entry_id_q    <= entry_id_d;
      busy_q        <= busy_d;
      sweep_cnt_q   <= sweep_cnt_d;
      err_overrun_q <= err_overrun_q | rx_overrun;
      cmd_stb_q     <= rx_valid & ~rx_rs;
      dat_stb_q     <= rx_valid & rx_rs;
      if (rx_valid) byte_out_q <= rx_byte;
    end
  end

  // Display RAM write; blocked during reset so an aborted sweep stops at once.
  always_ff @(posedge clk) begin
    if (we && reset) ram[waddr] <= wdata;
  end

  // Registered readback.
  always_ff @(posedge clk) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_mapped ? ram[rd_idx] : 8'h00;
  end

  assign rd_data_o     = rd_data_q;
  assign cmd_stb_o     = cmd_stb_q;
  assign dat_stb_o     = dat_stb_q;
  assign byte_out_o    = byte_out_q;
  assign ac_o          = ac_q;
  assign disp_ctl_o    = disp_ctl_q;
  assign entry_id_o    = entry_id_q;
  assign busy_o        = busy_q;
  assign err_overrun_o = err_overrun_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: scoreboard of executed bytes plus
// direct checks of status and readback.
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data, byte_out;
  logic [6:0] ac;
  logic [2:0] disp_ctl;
  logic       cmd_stb, dat_stb, mode_4bit, entry_id, busy, err_overrun;

  int n_checks = 0;
  int n_err    = 0;
  logic [8:0] sb_q[$];

  lcd_responder_if bus ();

  lcd_responder #(.DDRAM_COLS(16), .CLEAR_CHAR(8'h20)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .cmd_stb_o     (cmd_stb),
    .dat_stb_o     (dat_stb),
    .byte_out_o    (byte_out),
    .ac_o          (ac),
    .mode_4bit_o   (mode_4bit),
    .disp_ctl_o    (disp_ctl),
    .entry_id_o    (entry_id),
    .busy_o        (busy),
    .err_overrun_o (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every executed byte must match the oldest expected {rs, byte}.
  always @(negedge clk) begin
    if (cmd_stb || dat_stb) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {23'b0, dat_stb, byte_out}, 32'hFFFF);
      end else begin
        logic [8:0] exp;
        exp = sb_q.pop_front();
        check("sb_byte", {23'b0, dat_stb, byte_out}, {23'b0, exp});
        check("sb_onehot", {31'b0, cmd_stb & dat_stb}, 32'h0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rs_v, input logic [3:0] d);
    @(posedge clk); #1;
    bus.en = 1'b1; bus.rs = rs_v; bus.data = d;
    @(posedge clk); #1;
    bus.en = 1'b0;
  endtask

  task automatic send8(input logic rs_v, input logic [3:0] d);
    sb_q.push_back({rs_v, d, 4'h0});
    strobe(rs_v, d);
    idle(5);
  endtask

  task automatic send4(input logic rs_v, input logic [7:0] b);
    strobe(rs_v, b[7:4]);
    idle(2);
    sb_q.push_back({rs_v, b});
    strobe(rs_v, b[3:0]);
    idle(5);
  endtask

  task automatic read(input logic [6:0] a, output logic [7:0] v);
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    v = rd_data;
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
  endtask

  // Issue clear in 4-bit mode and count cycles spent busy (bounded).
  task automatic do_clear(output int busy_cycles);
    strobe(1'b0, 4'h0);
    idle(2);
    sb_q.push_back({1'b0, 8'h01});
    strobe(1'b0, 4'h1);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    #1;
  endtask

  initial begin
    int n;
    logic [7:0] v;
    bus.en = 1'b0; bus.rs = 1'b0; bus.data = 4'h0;
    do_reset(3);
    @(negedge clk);
    check("rst_ac", {25'b0, ac}, 32'h0);
    check("rst_mode", {31'b0, mode_4bit}, 32'h0);
    check("rst_dispctl", {29'b0, disp_ctl}, 32'h0);
    check("rst_entry", {31'b0, entry_id}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_err", {31'b0, err_overrun}, 32'h0);
    check("rst_stb", {30'b0, cmd_stb, dat_stb}, 32'h0);
    check("rst_byte", {24'b0, byte_out}, 32'h0);
    check("rst_rd", {24'b0, rd_data}, 32'h0);
    #1;

    // 8-bit init sequence then switch to 4-bit.
    send8(1'b0, 4'h3);
    send8(1'b0, 4'h3);
    send8(1'b0, 4'h3);
    check("mode_still8", {31'b0, mode_4bit}, 32'h0);
    send8(1'b0, 4'h2);
    check("mode_4bit", {31'b0, mode_4bit}, 32'h1);

    send4(1'b0, 8'h28);
    check("mode_after28", {31'b0, mode_4bit}, 32'h1);
    send4(1'b0, 8'h0C);
    check("dispctl", {29'b0, disp_ctl}, 32'h4);
    send4(1'b0, 8'h06);
    check("entry_inc", {31'b0, entry_id}, 32'h1);
    do_clear(n);
    check("clear_busy_cycles", n, 32);
    check("clear_ac", {25'b0, ac}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      logic [6:0] a;
      a = (i < 16) ? 7'(i) : 7'(8'h40 + i - 16);
      read(a, v);
      check($sformatf("clear_cell_%0h", a), {24'b0, v}, 32'h20);
    end

    // Address set and data write on row 1.
    send4(1'b0, 8'hC4);
    check("ac_44", {25'b0, ac}, 32'h44);
    send4(1'b1, 8'h30);
    check("ac_45", {25'b0, ac}, 32'h45);
    read(7'h44, v);
    check("rd_44", {24'b0, v}, 32'h30);
    read(7'h30, v);
    check("rd_gap", {24'b0, v}, 32'h0);
    read(7'h50, v);
    check("rd_col16", {24'b0, v}, 32'h0);

    // Row wrap, discarded write, decrement wrap.
    send4(1'b0, 8'hA7);
    send4(1'b1, 8'h41);
    check("wrap_27_40", {25'b0, ac}, 32'h40);
    read(7'h40, v);
    check("rd_40_untouched", {24'b0, v}, 32'h20);
    send4(1'b0, 8'h04);
    check("entry_dec", {31'b0, entry_id}, 32'h0);
    send4(1'b0, 8'h80);
    send4(1'b1, 8'h42);
    check("wrap_00_67", {25'b0, ac}, 32'h67);
    read(7'h00, v);
    check("rd_00", {24'b0, v}, 32'h42);

    // Cursor shift and gap-address stepping.
    send4(1'b0, 8'h14);
    check("shift_r_67", {25'b0, ac}, 32'h0);
    send4(1'b0, 8'h18);
    check("shift_sc_ignored", {25'b0, ac}, 32'h0);
    send4(1'b0, 8'hB0);
    send4(1'b0, 8'h10);
    check("gap_dec", {25'b0, ac}, 32'h27);
    send4(1'b0, 8'hE8);
    send4(1'b0, 8'h14);
    check("gap_inc", {25'b0, ac}, 32'h0);
    send4(1'b0, 8'h85);
    send4(1'b0, 8'h02);
    check("home", {25'b0, ac}, 32'h0);
    send4(1'b0, 8'h85);
    send4(1'b0, 8'h4A);
    check("cgram_noop", {25'b0, ac}, 32'h5);

    // Strobe while busy: flagged and dropped, phase unchanged.
    send4(1'b0, 8'h06);
    do_clear(n);
    check("ovr_err_pre", {31'b0, err_overrun}, 32'h0);
    sb_q.push_back({1'b0, 8'h01});
    strobe(1'b0, 4'h0);
    idle(2);
    strobe(1'b0, 4'h1);
    idle(3);
    strobe(1'b1, 4'h4);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("busy_drops", {31'b0, busy}, 32'h0);
    check("ovr_err", {31'b0, err_overrun}, 32'h1);
    send4(1'b1, 8'h31);
    read(7'h00, v);
    check("ovr_phase", {24'b0, v}, 32'h31);
    read(7'h01, v);
    check("ovr_cleared", {24'b0, v}, 32'h20);

    // Reset during sweep: earlier cells cleared, last cell kept.
    send4(1'b0, 8'hCF);
    send4(1'b1, 8'h55);
    send4(1'b0, 8'h80);
    send4(1'b1, 8'h66);
    strobe(1'b0, 4'h0);
    idle(2);
    sb_q.push_back({1'b0, 8'h01});
    strobe(1'b0, 4'h1);
    idle(7);
    do_reset(1);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_mode", {31'b0, mode_4bit}, 32'h0);
    read(7'h00, v);
    check("abort_first", {24'b0, v}, 32'h20);
    read(7'h4F, v);
    check("abort_last", {24'b0, v}, 32'h55);

    // Reset between nibbles of a byte.
    send8(1'b0, 4'h2);
    strobe(1'b1, 4'h4);
    idle(3);
    do_reset(2);
    check("midbyte_mode", {31'b0, mode_4bit}, 32'h0);
    check("midbyte_err", {31'b0, err_overrun}, 32'h0);
    send8(1'b0, 4'h2);
    check("midbyte_after", {31'b0, mode_4bit}, 32'h1);

    idle(4);
    check("sb_empty", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
